m_demux2_seq: RTL and testbench
===============================

M_DEMUX2_SEQ -- requirements
Module: m_demux2_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data path width in bits.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port IN_DATA  input  WIDTH  source word.
REQ-005 SHALL have port IN_VALID  input  1  source word present.
REQ-006 SHALL have port DEST  input  1  target channel: 0 selects channel 1, 1 selects channel 2.
REQ-007 SHALL have port IN_READY  output  1  target channel can accept this cycle.
REQ-008 SHALL have port OUT1  output  WIDTH  channel 1 data, zero when SEL1 is low.
REQ-009 SHALL have port SEL1  output  1  channel 1 holds a word.
REQ-010 SHALL have port ACK1  input  1  channel 1 consumer takes the word.
REQ-011 SHALL have ports OUT2, SEL2 and ACK2, identical to OUT1, SEL1 and ACK1, for channel 2.

Function
REQ-012 Each channel n SHALL own one WIDTH-bit holding register Hn and a two-state flag (EMPTY, FULL); SELn SHALL equal FULLn.
REQ-013 OUTn SHALL equal Hn AND-gated by SELn, so that OUT1|OUT2 recombines cleanly through a downstream AND-OR select.
REQ-014 Target channel t SHALL be taken from DEST.
REQ-015 IN_READY SHALL be combinational: (t is EMPTY) OR (ACKt high).
REQ-016 Accept SHALL occur when IN_VALID & IN_READY are both high; on the next edge Ht <= IN_DATA and t goes FULL.
REQ-017 Latency SHALL be 1 cycle: an accepted word is visible on OUTt with SELt high in the following cycle.
REQ-018 A drain on channel n SHALL occur when SELn & ACKn are both high; on the next edge n goes EMPTY unless reloaded in the same cycle.
REQ-019 A simultaneous drain and accept on the same channel SHALL leave it FULL holding the new word, sustaining 1 word/cycle.
REQ-020 ACKn asserted while SELn is low SHALL be ignored.
REQ-021 While FULL and not acked, Hn SHALL hold stable regardless of IN_DATA, IN_VALID and DEST.
REQ-022 The channels SHALL be independent: a blocked channel SHALL NOT stall accepts to, or drains from, the other channel.
REQ-023 IN_DATA and DEST SHALL have no effect when IN_VALID is low; unknown values there SHALL NOT propagate to any state.

Reset
REQ-024 RESET high at an edge SHALL force FULL1 = FULL2 = 0, H1 = H2 = 0 and the steering pointer to channel 1, so that OUT1 = OUT2 = 0, SEL1 = SEL2 = 0 and IN_READY = 1 (with ACKs low) in the following cycle.
REQ-025 RESET SHALL take priority over any simultaneous accept or drain; held words are discarded.

Configuration
REQ-026 Macro DEMUX2_ALTERNATE_EN SHALL select round-robin steering.
REQ-027 With DEMUX2_ALTERNATE_EN defined, DEST SHALL be ignored and t SHALL come from a 1-bit pointer, starting at channel 1 after reset and toggling only on accept.
REQ-028 With DEMUX2_ALTERNATE_EN undefined, no pointer SHALL exist and t SHALL follow DEST as in REQ-014.

Verification
REQ-029 Reset, then ACK1 = ACK2 = 0, IN_VALID = 0 -> OUT1 = OUT2 = 0x00, SEL1 = SEL2 = 0, IN_READY = 1.
REQ-030 DEST = 0, IN_DATA = 0x5A, IN_VALID for 1 cycle, ACK1 = 0 -> next cycle SEL1 = 1, OUT1 = 0x5A, SEL2 = 0, OUT2 = 0x00; values held for 10 cycles until ACK1, then SEL1 = 0 and OUT1 = 0x00.
REQ-031 Channel 1 full with 0x11 and ACK1 = 0, present 0x22 with DEST = 0 -> IN_READY = 0; raise ACK1 -> IN_READY = 1 that cycle, and next cycle OUT1 = 0x22 with SEL1 = 1.
REQ-032 Channel 1 full and blocked, present 0x33 with DEST = 1 -> accepted, next cycle SEL2 = 1, OUT2 = 0x33, OUT1 unchanged.
REQ-033 Both channels full, RESET for 1 cycle alongside IN_VALID and ACK1 -> next cycle all outputs 0, IN_READY = 1.
REQ-034 With DEMUX2_ALTERNATE_EN, ACKs high, DEST toggling randomly, accept 0x01, 0x02, 0x03, 0x04 back-to-back -> OUT1 shows 0x01 then 0x03, OUT2 shows 0x02 then 0x04.

Source files
------------

// File: rtl/m_demux2_seq_if.sv
// Source-side bus and two registered output channels for m_demux2_seq.
// Latency: none, wiring only. Backpressure: in_ready and ack1/ack2 carry the flow control.
// Master drives the source word and the acks; slave is the demux itself.
interface m_demux2_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             dest;
    logic             in_ready;
    logic [WIDTH-1:0] out1;
    logic             sel1;
    logic             ack1;
    logic [WIDTH-1:0] out2;
    logic             sel2;
    logic             ack2;

    modport master (
        output in_data, in_valid, dest, ack1, ack2,
        input  in_ready, out1, sel1, out2, sel2
    );

    modport slave (
        input  in_data, in_valid, dest, ack1, ack2,
        output in_ready, out1, sel1, out2, sel2
    );
endinterface

// File: rtl/m_demux2_seq.sv
// Two-channel demux, one holding register per channel; DEMUX2_ALTERNATE_EN selects round-robin steering.
// Latency: 1 cycle from accept to sel/out. Backpressure: in_ready drops while the target is full and not acked.
// The channels are independent, and a drain and reload in the same cycle sustain 1 word/cycle.
module m_demux2_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    m_demux2_seq_if.slave    bus
);

    logic [WIDTH-1:0] h1_q, h1_d;
    logic [WIDTH-1:0] h2_q, h2_d;
    logic             full1_q, full1_d;
    logic             full2_q, full2_d;
    logic             tgt;
    logic             in_ready;
    logic             acc1, acc2;
    logic             drain1, drain2;

`ifdef DEMUX2_ALTERNATE_EN
    logic ptr_q, ptr_d;
    assign tgt = ptr_q;
`else
    assign tgt = bus.dest;
`endif

    assign drain1   = full1_q & bus.ack1;
    assign drain2   = full2_q & bus.ack2;
    assign in_ready = tgt ? (~full2_q | bus.ack2) : (~full1_q | bus.ack1);

    // in_valid gates first so an unknown dest or in_data cannot reach any state
    assign acc1 = bus.in_valid & in_ready & ~tgt;
    assign acc2 = bus.in_valid & in_ready &  tgt;

    always_comb begin
        full1_d = acc1 | (full1_q & ~drain1);
        full2_d = acc2 | (full2_q & ~drain2);
        h1_d    = acc1 ? bus.in_data : h1_q;
        h2_d    = acc2 ? bus.in_data : h2_q;
    end

`ifdef DEMUX2_ALTERNATE_EN
    always_comb begin
        ptr_d = ptr_q ^ (acc1 | acc2);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full1_q <= 1'b0;
            full2_q <= 1'b0;
            h1_q    <= '0;
            h2_q    <= '0;
        end else begin
            full1_q <= full1_d;
            full2_q <= full2_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
        end
    end

    // AND-gating lets a downstream OR recombine both channels cleanly
    assign bus.in_ready = in_ready;
    assign bus.sel1     = full1_q;
    assign bus.sel2     = full2_q;
    assign bus.out1     = h1_q & {WIDTH{full1_q}};
    assign bus.out2     = h2_q & {WIDTH{full2_q}};

endmodule

// File: tb/tb_m_demux2_seq.sv
// Directed table-driven bench for m_demux2_seq plus hand-written multi-cycle sequences.
module tb_m_demux2_seq;

    logic clk_i = 1'b0;
    logic reset_i;
    int   checks   = 0;
    int   failures = 0;

    m_demux2_seq_if #(.WIDTH(8)) bus ();

    m_demux2_seq #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       dest;
        logic [7:0] dat;
        logic       a1;
        logic       a2;
        logic       e_rdy;
        logic       e_s1;
        logic [7:0] e_o1;
        logic       e_s2;
        logic [7:0] e_o2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rst, input logic vld, input logic dest,
                         input logic [7:0] dat, input logic a1, input logic a2);
        reset_i      = rst;
        bus.in_valid = vld;
        bus.dest     = dest;
        bus.in_data  = dat;
        bus.ack1     = a1;
        bus.ack2     = a2;
    endtask

    function automatic logic [31:0] obs();
        return {13'd0, bus.in_ready, bus.sel1, bus.out1, bus.sel2, bus.out2};
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {13'd0, v.e_rdy, v.e_s1, v.e_o1, v.e_s2, v.e_o2};
    endfunction

`ifndef DEMUX2_ALTERNATE_EN
    vec_t vecs[20];
`else
    vec_t vecs[6];
`endif

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();

`ifndef DEMUX2_ALTERNATE_EN
        //          rst vld dst dat    a1 a2  rdy s1 o1     s2 o2
        vecs[0]  = '{0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 8'h5A, 0, 0,  1, 0, 8'h00, 0, 8'h00};
        vecs[2]  = '{0, 0, 0, 8'h77, 0, 0,  0, 1, 8'h5A, 0, 8'h00};
        vecs[3]  = '{0, 0, 1, 8'h99, 0, 0,  1, 1, 8'h5A, 0, 8'h00};
        vecs[4]  = '{0, 0, 0, 8'h00, 1, 0,  1, 1, 8'h5A, 0, 8'h00};
        vecs[5]  = '{0, 0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 8'h00};
        vecs[6]  = '{0, 1, 0, 8'h11, 0, 0,  1, 0, 8'h00, 0, 8'h00};
        vecs[7]  = '{0, 1, 0, 8'h22, 0, 0,  0, 1, 8'h11, 0, 8'h00};
        vecs[8]  = '{0, 1, 0, 8'h22, 1, 0,  1, 1, 8'h11, 0, 8'h00};
        vecs[9]  = '{0, 1, 1, 8'h33, 0, 0,  1, 1, 8'h22, 0, 8'h00};
        vecs[10] = '{0, 1, 0, 8'h44, 0, 0,  0, 1, 8'h22, 1, 8'h33};
        vecs[11] = '{0, 1, 1, 8'h55, 0, 0,  0, 1, 8'h22, 1, 8'h33};
        vecs[12] = '{0, 1, 1, 8'h66, 0, 1,  1, 1, 8'h22, 1, 8'h33};
        vecs[13] = '{0, 1, 0, 8'h77, 1, 1,  1, 1, 8'h22, 1, 8'h66};
        vecs[14] = '{0, 0, 0, 8'h00, 1, 0,  1, 1, 8'h77, 0, 8'h00};
        vecs[15] = '{0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00};
        vecs[16] = '{0, 1, 0, 8'h88, 0, 0,  1, 0, 8'h00, 0, 8'h00};
        vecs[17] = '{0, 1, 1, 8'h99, 0, 0,  1, 1, 8'h88, 0, 8'h00};
        vecs[18] = '{1, 1, 0, 8'hAA, 1, 0,  1, 1, 8'h88, 1, 8'h99};
        vecs[19] = '{0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00};
`else
        // Round-robin: dest deliberately contradicts the pointer on every word
        vecs[0]  = '{0, 1, 1, 8'h01, 1, 1,  1, 0, 8'h00, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 8'h02, 1, 1,  1, 1, 8'h01, 0, 8'h00};
        vecs[2]  = '{0, 1, 1, 8'h03, 1, 1,  1, 0, 8'h00, 1, 8'h02};
        vecs[3]  = '{0, 1, 0, 8'h04, 1, 1,  1, 1, 8'h03, 0, 8'h00};
        vecs[4]  = '{0, 0, 1, 8'h00, 1, 1,  1, 0, 8'h00, 1, 8'h04};
        vecs[5]  = '{0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00};
`endif

        for (int i = 0; i < $size(vecs); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].dest, vecs[i].dat, vecs[i].a1, vecs[i].a2);
            @(negedge clk_i);
            check($sformatf("vec%0d", i), obs(), pack_exp(vecs[i]));
            tick();
        end

`ifndef DEMUX2_ALTERNATE_EN
        // Hold for 10 cycles while blocked traffic to channel 1 churns the inputs
        drive(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            @(negedge clk_i);
            check($sformatf("hold%0d", c), {22'd0, bus.sel1, bus.out1, bus.in_ready},
                  {22'd0, 1'b1, 8'h5A, 1'b0});
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk_i);
        check("drain_after_hold", {23'd0, bus.sel1, bus.out1}, {23'd0, 1'b0, 8'h00});

        // Unknown data and dest with in_valid low must leave both channels empty
        bus.in_valid = 1'b0;
        bus.dest     = 1'bx;
        bus.in_data  = 8'hxx;
        tick();
        tick();
        bus.dest    = 1'b0;
        bus.in_data = 8'h00;
        @(negedge clk_i);
        check("x_inputs_ignored", obs(), {13'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00});

        // Back-to-back streaming on channel 2 with ack held high: one word per cycle
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b1);
            @(negedge clk_i);
            check($sformatf("stream_rdy%0d", k), {31'd0, bus.in_ready}, 32'd1);
            tick();
            @(negedge clk_i);
            check($sformatf("stream_out%0d", k), {23'd0, bus.sel2, bus.out2},
                  {23'd0, 1'b1, 8'(8'hC0 + k)});
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
